// File: rtl/av_stream_slave.sv
// Avalon-MM 16-bit slave: DATA writes feed a FIFO drained as a valid/ready stream; STATUS/CTRL registers.
// Optional AVS_STALL_TIMEOUT_EN drops writes blocked on a full FIFO after TIMEOUT cycles and sets ovf.
module av_stream_slave #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             sysclk,
  input  logic             sysreset_n,
  input  logic [1:0]       av_address,
  input  logic             av_write,
  input  logic [WIDTH-1:0] av_writedata,
  input  logic             av_read,
  output logic [WIDTH-1:0] av_readdata,
  output logic             av_waitrequest,
  output logic [WIDTH-1:0] st_data,
  output logic             st_valid,
  input  logic             st_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RD_WAIT = 1'b1} rd_state_e;

  function automatic logic [15:0] status_word(input logic ovf, input logic [CW-1:0] cnt);
    status_word = {ovf, cnt == FULL_CNT, cnt == {CW{1'b0}}, 13'(cnt)};
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [WIDTH-1:0] st_data_r, head_nxt_s, av_readdata_r, rd_mux_s;
  logic             st_valid_r;
  rd_state_e        rd_state_r;
  logic             wr_data_s, wr_ctrl_s, full_s, empty_s, flush_s, blocked_s;
  logic             push_s, pop_s, rd_req_s, wr_stall_s, timeout_s, ovf_s;

  // Command decode and FIFO handshake qualification
  always_comb begin
    wr_data_s = av_write && (av_address == 2'd0);
    wr_ctrl_s = av_write && (av_address == 2'd2);
    full_s    = (count_r == FULL_CNT);
    empty_s   = (count_r == {CW{1'b0}});
    flush_s   = wr_ctrl_s && av_writedata[0];
    blocked_s = wr_data_s && full_s;
    push_s    = wr_data_s && !full_s && !flush_s;
    pop_s     = !empty_s && st_ready && !flush_s;
  end

`ifdef AVS_STALL_TIMEOUT_EN
  logic [15:0] stall_cnt_r;
  logic        ovf_r;

  assign timeout_s = blocked_s && (stall_cnt_r == 16'(TIMEOUT));
  assign ovf_s     = ovf_r;

  // Consecutive blocked-write counter and sticky overflow flag
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      stall_cnt_r <= 16'd0;
      ovf_r       <= 1'b0;
    end else begin
      if (blocked_s && !timeout_s) stall_cnt_r <= stall_cnt_r + 16'd1;
      else                         stall_cnt_r <= 16'd0;
      if (timeout_s)                          ovf_r <= 1'b1;
      else if (wr_ctrl_s && av_writedata[1])  ovf_r <= 1'b0;
      else                                    ovf_r <= ovf_r;
    end
  end
`else
  localparam int timeout_unused = TIMEOUT;
  assign timeout_s = 1'b0;
  assign ovf_s     = 1'b0;
`endif

  // Next pointer/count values; flush overrides any same-cycle push or pop
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush_s) begin
      wr_ptr_nxt_s = {AW{1'b0}};
      rd_ptr_nxt_s = {AW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_nxt_s = wr_ptr_r + AW'(1);
      else        wr_ptr_nxt_s = wr_ptr_r;
      if (pop_s)  rd_ptr_nxt_s = rd_ptr_r + AW'(1);
      else        rd_ptr_nxt_s = rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Head word after this edge; bypass when the incoming word lands at the new head
  always_comb begin
    if (count_nxt_s == {CW{1'b0}})                     head_nxt_s = {WIDTH{1'b0}};
    else if (push_s && (rd_ptr_nxt_s == wr_ptr_r))     head_nxt_s = av_writedata;
    else                                               head_nxt_s = mem_r[rd_ptr_nxt_s];
  end

  // Register read map
  always_comb begin
    case (av_address)
      2'd0:    rd_mux_s = st_data_r;
      2'd1:    rd_mux_s = status_word(ovf_s, count_r);
      default: rd_mux_s = {WIDTH{1'b0}};
    endcase
  end

  assign rd_req_s       = av_read && !av_write && (rd_state_r == IDLE);
  assign wr_stall_s     = blocked_s && !timeout_s;
  assign av_waitrequest = sysreset_n && (wr_stall_s || rd_req_s);

  // FIFO storage
  always_ff @(posedge sysclk) begin
    if (push_s) mem_r[wr_ptr_r] <= av_writedata;
  end

  // FIFO pointers, occupancy and registered stream outputs
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      st_valid_r <= 1'b0;
      st_data_r  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      st_valid_r <= (count_nxt_s != {CW{1'b0}});
      st_data_r  <= head_nxt_s;
    end
  end

  // Read FSM: one wait state, data captured on entry to RD_WAIT
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      rd_state_r    <= IDLE;
      av_readdata_r <= {WIDTH{1'b0}};
    end else begin
      case (rd_state_r)
        IDLE: begin
          if (rd_req_s) begin
            rd_state_r    <= RD_WAIT;
            av_readdata_r <= rd_mux_s;
          end else begin
            rd_state_r    <= IDLE;
          end
        end
        RD_WAIT: rd_state_r <= IDLE;
        default: rd_state_r <= IDLE;
      endcase
    end
  end

  assign st_data     = st_data_r;
  assign st_valid    = st_valid_r;
  assign av_readdata = av_readdata_r;

endmodule
